sprite_mover: RTL and testbench

- Parametrised successor of the maze cursor controller: moves an N×N sprite on the VGA-adapter framebuffer in response to direction keys.
- Checks the background image ROM for walls before each move, erases the old sprite, redraws it one step away, and flags a goal region.
- Feeds x/y/colour/plot straight into vga_adapter and drives the address of a 1-cycle-latency background ROM.

---
 rtl/sprite_mover.sv | 263 ++++++++++++++++++++++++++
 tb/tb_sprite_mover.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_mover.sv
`timescale 1ns / 1ps
// Sprite mover: walks an N x N sprite around the VGA framebuffer under key control,
// probing the background ROM for walls before each step and flagging a goal region.
module sprite_mover #(
  parameter int unsigned SCREEN_W              = 160,
  parameter int unsigned SCREEN_H              = 120,
  parameter int unsigned XW                    = 8,
  parameter int unsigned YW                    = 7,
  parameter int unsigned ADDR_W                = 15,
  parameter int unsigned COLOUR_W              = 6,
  parameter int unsigned SPRITE_SIZE           = 2,
  parameter int unsigned START_X               = 76,
  parameter int unsigned START_Y               = 29,
  parameter logic [COLOUR_W-1:0] SPRITE_COLOUR = 6'b110000,
  parameter logic [COLOUR_W-1:0] FREE_COLOUR   = 6'b000000,
  parameter int unsigned GOAL_X0               = 73,
  parameter int unsigned GOAL_X1               = 80,
  parameter int unsigned GOAL_Y0               = 114,
  parameter int unsigned GOAL_Y1               = 115
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                key_left,
  input  logic                key_right,
  input  logic                key_up,
  input  logic                key_down,
  input  logic                restart,
  output logic [ADDR_W-1:0]   bg_addr,
  input  logic [COLOUR_W-1:0] bg_colour,
  output logic [XW-1:0]       x,
  output logic [YW-1:0]       y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                goal_reached,
  output logic [XW-1:0]       pos_x,
  output logic [YW-1:0]       pos_y
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LastIdx  = CW'(SPRITE_SIZE - 1);
  localparam logic [CW-1:0] CheckEnd = CW'(SPRITE_SIZE);
  localparam logic [XW-1:0] StartX   = XW'(START_X);
  localparam logic [YW-1:0] StartY   = YW'(START_Y);

  typedef enum logic [2:0] {
    StIdle, StBound, StCheck, StErase, StDraw, StGoalChk, StGoal, StRestart
  } state_e;

  typedef enum logic [1:0] {DirLeft, DirRight, DirUp, DirDown} dir_e;

  state_e              state_q;
  dir_e                dir_q;
  logic [3:0]          key_q;
  logic                restart_q;
  logic [XW-1:0]       pos_x_q, tgt_x_q, x_q;
  logic [YW-1:0]       pos_y_q, tgt_y_q, y_q;
  logic [CW-1:0]       col_q, row_q, cnt_q;
  logic                blocked_q, goal_q, plot_q;
  logic [COLOUR_W-1:0] colour_q;
  logic [ADDR_W-1:0]   bg_addr_q;

  logic [3:0]    keys, key_rise;
  logic          restart_rise;
  logic          last_px, reject, in_goal, bg_free;
  logic [CW-1:0] col_nx, row_nx, chk_idx;
  logic [XW-1:0] lead_x;
  logic [YW-1:0] lead_y;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [XW-1:0] px,
                                                 input logic [YW-1:0] py);
    return ADDR_W'(py) * ADDR_W'(SCREEN_W) + ADDR_W'(px);
  endfunction

  // Bit 3 is left so the if-chain below gives left > right > up > down.
  assign keys         = {key_left, key_right, key_up, key_down};
  assign key_rise     = keys & ~key_q;
  assign restart_rise = restart & ~restart_q;
  assign bg_free      = (bg_colour == FREE_COLOUR);

  assign last_px = (col_q == LastIdx) && (row_q == LastIdx);
  assign col_nx  = (col_q == LastIdx) ? '0 : col_q + CW'(1);
  assign row_nx  = (col_q == LastIdx) ? row_q + CW'(1) : row_q;

  // Index of the leading-edge pixel whose address is issued at the end of this cycle.
  assign chk_idx = (state_q == StBound) ? '0 : cnt_q + CW'(1);

  always_comb begin
    lead_x = pos_x_q + XW'(chk_idx);
    lead_y = pos_y_q + YW'(chk_idx);
    unique case (dir_q)
      DirLeft:  lead_x = pos_x_q - XW'(1);
      DirRight: lead_x = pos_x_q + XW'(SPRITE_SIZE);
      DirUp:    lead_y = pos_y_q - YW'(1);
      DirDown:  lead_y = pos_y_q + YW'(SPRITE_SIZE);
    endcase
  end

  always_comb begin
    reject = 1'b0;
    unique case (dir_q)
      DirLeft:  reject = (pos_x_q == '0);
      DirRight: reject = (32'(pos_x_q) + SPRITE_SIZE) > (SCREEN_W - 1);
      DirUp:    reject = (pos_y_q == '0);
      DirDown:  reject = (32'(pos_y_q) + SPRITE_SIZE) > (SCREEN_H - 1);
    endcase
  end

  assign in_goal = (32'(pos_x_q) >= GOAL_X0) && (32'(pos_x_q) <= GOAL_X1) &&
                   (32'(pos_y_q) >= GOAL_Y0) && (32'(pos_y_q) <= GOAL_Y1);

  always_ff @(posedge clk) begin
    // Edge history tracks the inputs every cycle, so edges outside IDLE are dropped.
    key_q     <= keys;
    restart_q <= restart;
    if (!resetn) begin
      state_q   <= StDraw;
      dir_q     <= DirLeft;
      pos_x_q   <= StartX;
      pos_y_q   <= StartY;
      tgt_x_q   <= StartX;
      tgt_y_q   <= StartY;
      col_q     <= '0;
      row_q     <= '0;
      cnt_q     <= '0;
      blocked_q <= 1'b0;
      goal_q    <= 1'b0;
      plot_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      bg_addr_q <= '0;
    end else begin
      unique case (state_q)
        StIdle, StGoal: begin
          if (restart_rise) begin
            state_q  <= StRestart;
            plot_q   <= 1'b1;
            x_q      <= pos_x_q;
            y_q      <= pos_y_q;
            colour_q <= FREE_COLOUR;
            col_q    <= '0;
            row_q    <= '0;
          end else if (state_q == StIdle && |key_rise) begin
            state_q <= StBound;
            tgt_x_q <= pos_x_q;
            tgt_y_q <= pos_y_q;
            if (key_rise[3]) begin
              dir_q   <= DirLeft;
              tgt_x_q <= pos_x_q - XW'(1);
            end else if (key_rise[2]) begin
              dir_q   <= DirRight;
              tgt_x_q <= pos_x_q + XW'(1);
            end else if (key_rise[1]) begin
              dir_q   <= DirUp;
              tgt_y_q <= pos_y_q - YW'(1);
            end else begin
              dir_q   <= DirDown;
              tgt_y_q <= pos_y_q + YW'(1);
            end
          end
        end

        StBound: begin
          if (reject) begin
            state_q <= StIdle;
          end else begin
            state_q   <= StCheck;
            cnt_q     <= '0;
            blocked_q <= 1'b0;
            bg_addr_q <= pix_addr(lead_x, lead_y);
          end
        end

        // Addresses go out on cycles 0..N-1; ROM data for pixel k is judged on cycle k+1.
        StCheck: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q < LastIdx) bg_addr_q <= pix_addr(lead_x, lead_y);
          if (cnt_q != '0 && !bg_free) blocked_q <= 1'b1;
          if (cnt_q == CheckEnd) begin
            if (blocked_q || !bg_free) begin
              state_q <= StIdle;
            end else begin
              state_q  <= StErase;
              plot_q   <= 1'b1;
              x_q      <= pos_x_q;
              y_q      <= pos_y_q;
              colour_q <= FREE_COLOUR;
              col_q    <= '0;
              row_q    <= '0;
            end
          end
        end

        StErase, StRestart: begin
          if (last_px) begin
            state_q  <= StDraw;
            colour_q <= SPRITE_COLOUR;
            col_q    <= '0;
            row_q    <= '0;
            if (state_q == StRestart) begin
              pos_x_q <= StartX;
              pos_y_q <= StartY;
              x_q     <= StartX;
              y_q     <= StartY;
              goal_q  <= 1'b0;
            end else begin
              pos_x_q <= tgt_x_q;
              pos_y_q <= tgt_y_q;
              x_q     <= tgt_x_q;
              y_q     <= tgt_y_q;
            end
          end else begin
            col_q <= col_nx;
            row_q <= row_nx;
            x_q   <= pos_x_q + XW'(col_nx);
            y_q   <= pos_y_q + YW'(row_nx);
          end
        end

        // After reset plot is low on entry, so the first cycle only loads pixel 0.
        StDraw: begin
          if (!plot_q) begin
            plot_q   <= 1'b1;
            x_q      <= pos_x_q;
            y_q      <= pos_y_q;
            colour_q <= SPRITE_COLOUR;
            col_q    <= '0;
            row_q    <= '0;
          end else if (last_px) begin
            plot_q  <= 1'b0;
            state_q <= StGoalChk;
          end else begin
            col_q <= col_nx;
            row_q <= row_nx;
            x_q   <= pos_x_q + XW'(col_nx);
            y_q   <= pos_y_q + YW'(row_nx);
          end
        end

        StGoalChk: begin
          if (in_goal) begin
            goal_q  <= 1'b1;
            state_q <= StGoal;
          end else begin
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign bg_addr      = bg_addr_q;
  assign x            = x_q;
  assign y            = y_q;
  assign colour       = colour_q;
  assign plot         = plot_q;
  assign busy         = !(state_q == StIdle || state_q == StGoal);
  assign goal_reached = goal_q;
  assign pos_x        = pos_x_q;
  assign pos_y        = pos_y_q;

endmodule

// File: tb/tb_sprite_mover.sv
`timescale 1ns / 1ps
// Bench for sprite_mover: a pixel-level model of moves/restarts predicts the plot stream,
// final position, goal flag and busy duration; directed literals pin the timing.
module tb_sprite_mover;

  localparam int N = 2;
  localparam int W = 160;
  localparam int H = 120;

  logic        clk = 1'b0;
  logic        resetn, key_left, key_right, key_up, key_down, restart;
  logic [14:0] bg_addr;
  logic [5:0]  bg_colour;
  logic [7:0]  x, pos_x;
  logic [6:0]  y, pos_y;
  logic [5:0]  colour;
  logic        plot, busy, goal_reached;

  always #5 clk = ~clk;

  sprite_mover dut (
    .clk(clk), .resetn(resetn),
    .key_left(key_left), .key_right(key_right), .key_up(key_up), .key_down(key_down),
    .restart(restart), .bg_addr(bg_addr), .bg_colour(bg_colour),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy),
    .goal_reached(goal_reached), .pos_x(pos_x), .pos_y(pos_y)
  );

  typedef struct { int px; int py; int c; } pix_t;
  pix_t exp_q[$];
  pix_t e_cur;
  int   mx, my;
  bit   mgoal;
  int   n_checks = 0, n_fail = 0, plot_cnt = 0;

  // Background: one wall pixel just above the sprite's first resting place.
  function automatic int rom_at(input int px, input int py);
    return (px == 77 && py == 28) ? 'h3F : 0;
  endfunction

  always @(posedge clk) bg_colour <= 6'(rom_at(int'(bg_addr) % W, int'(bg_addr) / W));

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic void paint(input int px, input int py, input int c);
    for (int r = 0; r < N; r++)
      for (int q = 0; q < N; q++) exp_q.push_back('{px + q, py + r, c});
  endfunction

  // Returns expected busy cycles; d: 0 left, 1 right, 2 up, 3 down.
  function automatic int model_move(input int d);
    int nx, ny, lx, ly;
    bit wall;
    nx = mx; ny = my; wall = 0;
    if (mgoal) return 0;
    if ((d == 0 && mx == 0) || (d == 2 && my == 0) ||
        (d == 1 && mx + N > W - 1) || (d == 3 && my + N > H - 1)) return 1;
    case (d)
      0: nx = mx - 1;
      1: nx = mx + 1;
      2: ny = my - 1;
      default: ny = my + 1;
    endcase
    for (int i = 0; i < N; i++) begin
      lx = (d == 0) ? nx : (d == 1) ? nx + N - 1 : nx + i;
      ly = (d == 2) ? ny : (d == 3) ? ny + N - 1 : ny + i;
      if (rom_at(lx, ly) != 0) wall = 1;
    end
    if (wall) return N + 2;
    paint(mx, my, 0);
    mx = nx; my = ny;
    paint(mx, my, 'h30);
    if (mx >= 73 && mx <= 80 && my >= 114 && my <= 115) mgoal = 1;
    return N + 3 + 2 * N * N;
  endfunction

  function automatic int model_restart();
    paint(mx, my, 0);
    mx = 76; my = 29; mgoal = 0;
    paint(mx, my, 'h30);
    return 2 * N * N + 1;
  endfunction

  always @(negedge clk) begin
    if (plot === 1'b1) begin
      plot_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected plot", 1, 0);
      end else begin
        e_cur = exp_q.pop_front();
        check("plot x", int'(x), e_cur.px);
        check("plot y", int'(y), e_cur.py);
        check("plot colour", int'(colour), e_cur.c);
      end
    end
  end

  task automatic press(input logic [3:0] k, input logic r, input int hold, input int exp_busy,
                       input string tag, output int busy_n);
    int pc0, exp_plots, a0;
    pc0 = plot_cnt; a0 = int'(bg_addr); busy_n = 0; exp_plots = exp_q.size();
    @(posedge clk); #1;
    {key_left, key_right, key_up, key_down} = k;
    restart = r;
    for (int c = 0; c < hold + 3 * N * N + N + 12; c++) begin
      @(posedge clk); #1;
      if (c == hold - 1) begin
        {key_left, key_right, key_up, key_down} = 4'b0;
        restart = 1'b0;
      end
      if (busy) busy_n++;
    end
    check({tag, " busy cycles"}, busy_n, exp_busy);
    check({tag, " plot count"}, plot_cnt - pc0, exp_plots);
    check({tag, " pending plots"}, exp_q.size(), 0);
    check({tag, " pos_x"}, int'(pos_x), mx);
    check({tag, " pos_y"}, int'(pos_y), my);
    check({tag, " goal"}, int'(goal_reached), int'(mgoal));
    check({tag, " idle"}, int'(busy), 0);
    if (exp_busy <= 1) check({tag, " no rom read"}, int'(bg_addr), a0);
  endtask

  task automatic do_move(input int d, input int hold, input string tag, output int busy_n);
    int eb;
    eb = model_move(d);
    press(4'b1000 >> d, 1'b0, hold, eb, tag, busy_n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish within 2 ms");
    $fatal(1);
  end

  initial begin
    int bn, eb, done_at;
    bit seen;
    resetn = 1'b0; restart = 1'b0;
    {key_left, key_right, key_up, key_down} = 4'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset plot", int'(plot), 0);
    check("reset x", int'(x), 0);
    check("reset y", int'(y), 0);
    check("reset colour", int'(colour), 0);
    check("reset bg_addr", int'(bg_addr), 0);
    check("reset goal", int'(goal_reached), 0);
    check("reset pos_x", int'(pos_x), 76);
    check("reset pos_y", int'(pos_y), 29);
    check("reset busy", int'(busy), 1);
    mx = 76; my = 29; mgoal = 0;
    paint(mx, my, 'h30);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("init draw plot", int'(plot), 1);
    check("init draw x0", int'(x), 76);
    check("init draw y0", int'(y), 29);
    check("init draw colour", int'(colour), 'h30);
    @(posedge clk); #1;
    check("init draw x1", int'(x), 77);
    @(posedge clk); #1;
    check("init draw y2", int'(y), 30);
    @(posedge clk); #1;
    check("init draw x3", int'(x), 77);
    check("init draw y3", int'(y), 30);
    @(posedge clk); #1;
    check("init draw end plot", int'(plot), 0);
    check("init goalchk busy", int'(busy), 1);
    @(posedge clk); #1;
    check("init idle", int'(busy), 0);
    check("init pending plots", exp_q.size(), 0);

    // Right move with cycle-exact timing literals.
    eb = model_move(1);
    check("model right busy", eb, 13);
    key_right = 1'b1;
    @(posedge clk); #1;
    check("right bound busy", int'(busy), 1);
    @(posedge clk); #1;
    check("right check addr0", int'(bg_addr), 4718);
    @(posedge clk); #1;
    check("right check addr1", int'(bg_addr), 4878);
    key_right = 1'b0;
    @(posedge clk); #1;
    check("right no plot in check", int'(plot), 0);
    @(posedge clk); #1;
    check("right first erase plot", int'(plot), 1);
    check("right first erase x", int'(x), 76);
    check("right first erase colour", int'(colour), 0);
    done_at = -1;
    for (int c = 6; c < 40; c++) begin
      @(posedge clk); #1;
      if (!busy) begin
        done_at = c;
        break;
      end
    end
    check("right move end cycle", done_at, 14);
    check("right pos_x", int'(pos_x), 77);
    check("right pos_y", int'(pos_y), 29);
    check("right pending plots", exp_q.size(), 0);

    do_move(2, 2, "up blocked", bn);
    check("up blocked busy literal", bn, 4);
    do_move(1, 100, "held right", bn);
    check("held right pos literal", int'(pos_x), 78);
    eb = model_move(0);
    press(4'b1001, 1'b0, 2, eb, "left+down", bn);
    check("left wins pos_x", int'(pos_x), 77);
    check("left wins pos_y", int'(pos_y), 29);

    for (int i = 0; i < 77; i++) do_move(0, 2, "walk left", bn);
    check("left edge pos literal", int'(pos_x), 0);
    do_move(0, 2, "left at edge", bn);
    check("left edge reject literal", bn, 1);
    for (int i = 0; i < 158; i++) do_move(1, 2, "walk right", bn);
    check("right edge pos literal", int'(pos_x), 158);
    do_move(1, 2, "right at edge", bn);
    check("right edge reject literal", bn, 1);
    for (int i = 0; i < 82; i++) do_move(0, 2, "back left", bn);
    for (int i = 0; i < 85; i++) do_move(3, 2, "walk down", bn);
    check("goal pos_y literal", int'(pos_y), 114);
    check("goal flag literal", int'(goal_reached), 1);
    do_move(3, 2, "key in goal", bn);
    check("goal ignores keys literal", bn, 0);

    eb = model_restart();
    press(4'b0, 1'b1, 2, eb, "restart", bn);
    check("restart busy literal", bn, 9);
    check("restart pos_x literal", int'(pos_x), 76);
    check("restart goal literal", int'(goal_reached), 0);

    // Reset asserted during an erase.
    do_move(1, 2, "pre-reset move", bn);
    eb = model_move(1);
    @(posedge clk); #1;
    key_right = 1'b1;
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (plot === 1'b1) seen = 1;
      if (c == 2) key_right = 1'b0;
    end
    key_right = 1'b0;
    check("erase seen before reset", int'(seen), 1);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("mid reset plot", int'(plot), 0);
    check("mid reset pos_x", int'(pos_x), 76);
    check("mid reset pos_y", int'(pos_y), 29);
    check("mid reset busy", int'(busy), 1);
    exp_q.delete();
    mx = 76; my = 29; mgoal = 0;
    paint(mx, my, 'h30);
    resetn = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post reset idle", int'(busy), 0);
    check("post reset pending plots", exp_q.size(), 0);
    check("post reset pos_x", int'(pos_x), 76);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
